input_debouncer: RTL

- Conditions the raw asynchronous input that drives the sequence-detector FSM input `a`.
- Synchronises `raw_in` into the `clk` domain and debounces it with a four-state FSM and a stability counter.
- Presents a clean registered level `a_out`, plus one-cycle rise/fall pulses.
- Sits directly upstream of the detector: `a_out` connects to its `a` input.

---
 rtl/input_debouncer_if.sv | 22 ++
 rtl/input_debouncer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/input_debouncer_if.sv
// Signal bundle between the raw-input source and the debouncer.
// The bounce_cnt member exists only when DEBOUNCE_BOUNCE_CNT_EN is defined.
interface input_debouncer_if;
  logic       raw_in;
  logic       a_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
`ifdef DEBOUNCE_BOUNCE_CNT_EN
  logic [7:0] bounce_cnt;

  modport master (output raw_in, input a_out, input rise_pulse, input fall_pulse,
                  input busy, input bounce_cnt);
  modport slave  (input raw_in, output a_out, output rise_pulse, output fall_pulse,
                  output busy, output bounce_cnt);
`else
  modport master (output raw_in, input a_out, input rise_pulse, input fall_pulse,
                  input busy);
  modport slave  (input raw_in, output a_out, output rise_pulse, output fall_pulse,
                  output busy);
`endif
endinterface

// File: rtl/input_debouncer.sv
// Synchronises and debounces raw_in into a clean level a_out with rise/fall pulses.
// Optional abort counter output bounce_cnt is enabled by defining DEBOUNCE_BOUNCE_CNT_EN.
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  input_debouncer_if.slave  dbif
);

  localparam int              CW       = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain_r;
  logic                   sync_s;
  state_t                 state_r;
  logic [CW-1:0]          cnt_r;
  logic                   a_out_r;
  logic                   rise_r;
  logic                   fall_r;

  assign sync_s = sync_chain_r[SYNC_STAGES-1];

  // Synchroniser chain: raw_in enters at bit 0, sync_s is the last stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], dbif.raw_in};
    end
  end

  // Debounce FSM with stability counter and registered level/pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= LOW;
      cnt_r   <= {CW{1'b0}};
      a_out_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        LOW: begin
          if (sync_s) begin
            state_r <= CHK_HI;
            cnt_r   <= {CW{1'b0}};
          end else begin
            state_r <= LOW;
          end
        end
        CHK_HI: begin
          if (!sync_s) begin
            state_r <= LOW;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            state_r <= HIGH;
            cnt_r   <= {CW{1'b0}};
            a_out_r <= 1'b1;
            rise_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        HIGH: begin
          if (!sync_s) begin
            state_r <= CHK_LO;
            cnt_r   <= {CW{1'b0}};
          end else begin
            state_r <= HIGH;
          end
        end
        CHK_LO: begin
          if (sync_s) begin
            state_r <= HIGH;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            state_r <= LOW;
            cnt_r   <= {CW{1'b0}};
            a_out_r <= 1'b0;
            fall_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          // Corrupted state: recover to the reset condition.
          state_r <= LOW;
          cnt_r   <= {CW{1'b0}};
          a_out_r <= 1'b0;
        end
      endcase
    end
  end

  assign dbif.a_out      = a_out_r;
  assign dbif.rise_pulse = rise_r;
  assign dbif.fall_pulse = fall_r;
  assign dbif.busy       = (state_r == CHK_HI) || (state_r == CHK_LO);

`ifdef DEBOUNCE_BOUNCE_CNT_EN
  logic       abort_s;
  logic [7:0] bounce_cnt_r;

  assign abort_s = ((state_r == CHK_HI) && !sync_s) || ((state_r == CHK_LO) && sync_s);

  // Saturating count of aborted qualifications, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bounce_cnt_r <= 8'd0;
    end else if (abort_s && (bounce_cnt_r != 8'd255)) begin
      bounce_cnt_r <= bounce_cnt_r + 8'd1;
    end else begin
      bounce_cnt_r <= bounce_cnt_r;
    end
  end

  assign dbif.bounce_cnt = bounce_cnt_r;
`endif

endmodule
